// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC-driven req/ack to imem, small buffer toward decode.
// Drives fetch_stall so the PC advances once per accepted word or on redirect.
module if_fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        id_stall,
  output logic [31:0] pc_plus4,
  output logic        fetch_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc4   [DEPTH];
  logic          pop;
  logic          accept;
  logic [31:0]   next_addr;

  assign pop       = ifid_valid & ~id_stall & ~flush;
  assign accept    = (state == WAIT) & imem_ack & ~flush;
  assign count_nxt = count + CW'(accept) - CW'(pop);
  assign next_addr = imem_addr + 32'd4;

  assign pc_plus4      = pc + 32'd4;
  assign fetch_stall   = ~(accept | flush);
  assign ifid_valid    = (count != '0);
  assign ifid_instr    = buf_instr[rd_ptr];
  assign ifid_pc_plus4 = buf_pc4[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!flush && count < FULL) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            if (!flush && count_nxt < FULL) begin
              imem_addr <= next_addr;
            end else begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // the response still owed to memory is swallowed here
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc4[i]   <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (accept) begin
        buf_instr[wr_ptr] <= imem_rdata;
        buf_pc4[wr_ptr]   <= next_addr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: PC stage + memory model + program-order
// scoreboard of what decode must consume.
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        flush;
  logic        id_stall;
  logic [31:0] pc_plus4;
  logic        fetch_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;

  if_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .flush        (flush),
    .id_stall     (id_stall),
    .pc_plus4     (pc_plus4),
    .fetch_stall  (fetch_stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  // addresses decode must see, in program order since the last redirect
  logic [31:0] exp_q [$];

  int          cnt;
  bit          stale;
  bit          prev_hold;
  logic [31:0] prev_addr;
  logic [31:0] tgt;
  bit          rst_done;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // monitor: every consumed head entry must be the next word in program order
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && ifid_valid && !id_stall && !flush) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got entry %h want none", ifid_pc_plus4);
        end else begin
          a = exp_q.pop_front();
          check("ifid_instr", ifid_instr, mem_word(a));
          check("ifid_pc_plus4", ifid_pc_plus4, a + 32'd4);
          pops++;
        end
      end
    end
  end

  initial begin
    bit          req_s, ack_s, acc, pp, fl_s;
    logic [31:0] addr_s;
    pc = 32'h0; flush = 1'b0; id_stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; tgt = 32'h0;
    rst_n = 1'b0; cnt = 0; stale = 1'b0; prev_hold = 1'b0;
    prev_addr = 32'h0; rst_done = 1'b0;
    refill(32'h0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(ifid_valid), 32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4", ifid_pc_plus4, 32'h0);
    check("rst_stall", 32'(fetch_stall), 32'h1);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc < 40) begin
        id_stall = 1'b0;
        flush    = 1'b0;
        imem_ack = imem_req;
      end else if (cyc < 70) begin
        id_stall = 1'b1;
        flush    = 1'b0;
        imem_ack = imem_req & ($urandom_range(0, 2) != 0);
      end else begin
        id_stall = ((cyc % 100) < 15) || ($urandom_range(0, 3) == 0);
        flush    = ($urandom_range(0, 23) == 0) || (cyc == 200);
        imem_ack = imem_req & ($urandom_range(0, 2) != 0);
        if (cyc == 200) tgt = 32'hFFFF_FFF8;
        else if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0;
        else tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      end
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
      #1;
      req_s  = imem_req;
      ack_s  = imem_ack;
      addr_s = imem_addr;
      fl_s   = flush;
      acc    = req_s & ack_s & ~stale & ~fl_s;
      pp     = ifid_valid & ~id_stall & ~fl_s;
      check("pc_plus4", pc_plus4, pc + 32'd4);
      check("fetch_stall", 32'(fetch_stall), 32'(!(fl_s || acc)));
      check("ifid_valid", 32'(ifid_valid), 32'(cnt != 0));
      if (req_s && !stale) check("req_addr", imem_addr, pc);
      if (cnt == DEPTH) check("full_no_req", 32'(imem_req), 32'h0);
      if (prev_hold) begin
        check("req_hold", 32'(imem_req), 32'h1);
        check("addr_hold", imem_addr, prev_addr);
      end

      @(posedge clk);
      #1;
      if (fl_s) begin
        pc  = tgt;
        cnt = 0;
        refill(tgt);
      end else begin
        if (acc) pc = pc + 32'd4;
        cnt = cnt + int'(acc) - int'(pp);
      end
      if (ack_s) stale = 1'b0;
      else if (fl_s && req_s) stale = 1'b1;
      prev_hold = req_s & ~ack_s;
      prev_addr = addr_s;

      if (cyc >= 1500 && !rst_done && imem_req) begin
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(imem_req), 32'h0);
        check("async_rst_valid", 32'(ifid_valid), 32'h0);
        pc = 32'h200; cnt = 0; stale = 1'b0; prev_hold = 1'b0;
        refill(32'h200);
        rst_done = 1'b1;
        @(negedge clk);
        flush = 1'b0; imem_ack = 1'b0; id_stall = 1'b0;
        rst_n = 1'b1;
      end
    end

    total++;
    if (pops < 100) begin
      bad++;
      $display("FAIL progress: got %0d pops want >= 100", pops);
    end
    total++;
    if (!rst_done) begin
      bad++;
      $display("FAIL rst_inject: got 0 want 1");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
